load_store_unit: RTL and testbench

Initiator side of the data-memory interface. Takes one load or store request at a time from the execute stage and checks alignment and address range. It then drives the word-addressed data memory's address, write-data, write and read strobes for a fixed access latency. It returns one response (read data or error) to the pipeline for each accepted request.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory initiator bundle: pipeline request/response plus the
// word-addressed memory port. 'slave' is the unit's view, 'master' is the
// pipeline/memory environment's view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_signed, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_signed, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, alignment/range check, fixed
// MEM_LAT strobe hold, one response pulse per accepted request.
// Optional macro SUBWORD_EN: byte/half loads (lane extract + extension) and
// sub-word stores via read-modify-write. Without it every access is a word.
module load_store_unit #(
  parameter int DEPTH_WORDS = 64,
  parameter int MEM_LAT     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);
`ifdef SUBWORD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RMW_RD = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd2, RESP = 2'd3} state_t;
`endif

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t      state, nxt;
  logic [CW-1:0] cnt;
  logic        last;
  logic        ready_q;
  logic        accept;
  logic        misal, oor, req_err;
  logic        wr_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] load_val;

`ifdef SUBWORD_EN
  logic        rmw;
  logic [1:0]  lo_q, size_q;
  logic        sgn_q;
  logic [4:0]  lane;
  logic [31:0] sh, msk, merged;
`else
  logic        unused_sub;
  assign unused_sub = ^{bus.req_size, bus.req_signed};
`endif

  assign accept = bus.req_valid && ready_q;
  assign last   = (cnt == CW'(MEM_LAT - 1));

  // Request legality: alignment by access size, word index within memory
  always_comb begin
    misal = |bus.req_addr[1:0];
`ifdef SUBWORD_EN
    case (bus.req_size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = bus.req_addr[0];
      2'b10:   misal = |bus.req_addr[1:0];
      default: misal = 1'b1;
    endcase
    rmw = bus.req_write && (bus.req_size != 2'b10);
`endif
    oor     = {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS);
    req_err = misal | oor;
  end

`ifdef SUBWORD_EN
  // Lane extraction for loads and lane merge for read-modify-write stores
  always_comb begin
    lane     = {lo_q, 3'b000};
    sh       = bus.mem_rdata >> lane;
    case (size_q)
      2'b00:   load_val = {{24{sgn_q & sh[7]}}, sh[7:0]};
      2'b01:   load_val = {{16{sgn_q & sh[15]}}, sh[15:0]};
      default: load_val = bus.mem_rdata;
    endcase
    msk      = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << lane;
    merged   = (bus.mem_rdata & ~msk) | ((wdata_q << lane) & msk);
  end
`else
  assign load_val = bus.mem_rdata;
`endif

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state: errors skip the memory entirely
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) nxt = RESP;
`ifdef SUBWORD_EN
          else if (rmw) nxt = RMW_RD;
`endif
          else nxt = ACCESS;
        end
      end
`ifdef SUBWORD_EN
      RMW_RD: if (last) nxt = ACCESS;
`endif
      ACCESS:  if (last) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: request latch, latency counter, read capture, ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef SUBWORD_EN
      lo_q    <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
`endif
    end else begin
      // ready tracks IDLE one edge late so it stays low through reset
      ready_q <= (nxt == IDLE);
      if (state == ACCESS
`ifdef SUBWORD_EN
          || state == RMW_RD
`endif
         ) cnt <= last ? '0 : cnt + 1'b1;
      else cnt <= '0;

      if (accept) begin
        wr_q    <= bus.req_write;
        err_q   <= req_err;
        rdata_q <= '0;
`ifdef SUBWORD_EN
        lo_q    <= bus.req_addr[1:0];
        size_q  <= bus.req_size;
        sgn_q   <= bus.req_signed;
`endif
        // memory-facing address/data only move for accesses that go out
        if (!req_err) begin
          addr_q <= {2'b00, bus.req_addr[31:2]};
          if (bus.req_write) wdata_q <= bus.req_wdata;
        end
      end

      if (state == ACCESS && last && !wr_q) rdata_q <= load_val;
`ifdef SUBWORD_EN
      if (state == RMW_RD && last) wdata_q <= merged;
`endif
    end
  end

  // Outputs: strobes decoded from state so reset drops them at once
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = (state == RESP) ? rdata_q : 32'h0;
  assign bus.rsp_err   = (state == RESP) && err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state == ACCESS) && wr_q;
`ifdef SUBWORD_EN
  assign bus.mem_re    = (state == RMW_RD) || ((state == ACCESS) && !wr_q);
`else
  assign bus.mem_re    = (state == ACCESS) && !wr_q;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random requests against a
// transaction-level model (reference memory + per-request expected response).
module tb_load_store_unit;
  localparam int DEPTH = 64;
  localparam int L     = 3;
  localparam int AW    = $clog2(DEPTH);

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  load_store_unit_if ifc();

  load_store_unit #(.DEPTH_WORDS(DEPTH), .MEM_LAT(L)) u_dut (
    .clk   (gclk),
    .rst_n (grst_n),
    .bus   (ifc)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
  endfunction

  // environment memory: written by the DUT, combinational read
  logic [31:0]      tbmem [DEPTH];
  logic [DEPTH-1:0] tbwr;
  logic             mem_clr = 1'b1;
  logic [31:0]      mrd;

  always @(posedge gclk or posedge mem_clr) begin
    if (mem_clr) tbwr <= '0;
    else if (ifc.mem_we && ifc.mem_addr < 32'(DEPTH)) begin
      tbwr[ifc.mem_addr[AW-1:0]]  <= 1'b1;
      tbmem[ifc.mem_addr[AW-1:0]] <= ifc.mem_wdata;
    end
  end

  always_comb begin
    mrd = 32'h0;
    if (ifc.mem_addr < 32'(DEPTH))
      mrd = tbwr[ifc.mem_addr[AW-1:0]] ? tbmem[ifc.mem_addr[AW-1:0]] : seed(int'(ifc.mem_addr[AW-1:0]));
  end
  assign ifc.mem_rdata = mrd;

  // reference memory
  logic [31:0] ref_mem [DEPTH];

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz_in, input logic sg);
    logic        err;
    logic [1:0]  sz;
    logic [31:0] idx, exp_rd, exp_ww, old, msk, wmask;
    logic [31:0] got_addr, got_wd, got_rd;
    logic        got_err, leak, rdy_bad;
    int lat, ere, ewe, nre, nwe, both, npulse, rsp_at, lane, n;
    sz = sz_in;
    idx = {2'b00, a[31:2]};
    lane = 8 * int'(a[1:0]);
    err = (idx >= 32'(DEPTH));
`ifdef SUBWORD_EN
    case (sz)
      2'b00: ;
      2'b01: if (a[0]) err = 1'b1;
      2'b10: if (a[1:0] != 2'b00) err = 1'b1;
      default: err = 1'b1;
    endcase
`else
    if (a[1:0] != 2'b00) err = 1'b1;
    sz = 2'b10;
`endif
    exp_rd = 0; exp_ww = 0; ere = 0; ewe = 0;
    if (err) lat = 1;
    else if (!w) begin
      ere = L; lat = L + 1;
      old = ref_mem[idx[AW-1:0]];
      if (sz == 2'b00) begin
        exp_rd = (old >> lane) & 32'd255;
        if (sg && exp_rd >= 32'd128) exp_rd = exp_rd - 32'd256;
      end else if (sz == 2'b01) begin
        exp_rd = (old >> lane) & 32'd65535;
        if (sg && exp_rd >= 32'd32768) exp_rd = exp_rd - 32'd65536;
      end else exp_rd = old;
    end else if (sz == 2'b10) begin
      ewe = L; lat = L + 1; exp_ww = d;
      ref_mem[idx[AW-1:0]] = d;
    end else begin
      ere = L; ewe = L; lat = 2 * L + 1;
      wmask = (sz == 2'b00) ? 32'd255 : 32'd65535;
      msk = wmask << lane;
      exp_ww = (ref_mem[idx[AW-1:0]] & ~msk) | ((d & wmask) << lane);
      ref_mem[idx[AW-1:0]] = exp_ww;
    end

    ifc.req_write = w; ifc.req_addr = a; ifc.req_wdata = d;
    ifc.req_size = sz_in; ifc.req_signed = sg; ifc.req_valid = 1'b1;
    n = 0;
    while (!ifc.req_ready && n < 20) begin @(negedge gclk); n++; end
    chk("ready", 32'(ifc.req_ready), 32'd1);
    @(negedge gclk);
    ifc.req_valid = 1'b0;
    nre = 0; nwe = 0; both = 0; npulse = 0; rsp_at = -1;
    got_addr = 0; got_wd = 0; got_rd = 0; got_err = 0; leak = 0; rdy_bad = 0;
    for (int c = 1; c <= lat + 1; c++) begin
      if (ifc.mem_re) nre++;
      if (ifc.mem_we) begin nwe++; got_wd = ifc.mem_wdata; end
      if (ifc.mem_re || ifc.mem_we) got_addr = ifc.mem_addr;
      if (ifc.mem_re && ifc.mem_we) both++;
      if (ifc.rsp_valid) begin
        npulse++; rsp_at = c; got_rd = ifc.rsp_rdata; got_err = ifc.rsp_err;
      end else if (ifc.rsp_rdata != 0 || ifc.rsp_err) leak = 1'b1;
      if (c <= lat && ifc.req_ready) rdy_bad = 1'b1;
      if (c == lat + 1) chk("ready_back", 32'(ifc.req_ready), 32'd1);
      else @(negedge gclk);
    end
    chk("re_cycles", 32'(nre), 32'(ere));
    chk("we_cycles", 32'(nwe), 32'(ewe));
    chk("re_we_both", 32'(both), 32'd0);
    chk("rsp_pulses", 32'(npulse), 32'd1);
    chk("rsp_cycle", 32'(rsp_at), 32'(lat));
    chk("rsp_err", 32'(got_err), 32'(err));
    chk("rsp_rdata", got_rd, exp_rd);
    chk("rsp_idle_zero", 32'(leak), 32'd0);
    chk("ready_low", 32'(rdy_bad), 32'd0);
    if (ere + ewe > 0) chk("mem_addr", got_addr, idx);
    if (ewe > 0) chk("mem_wdata", got_wd, exp_ww);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, low, re, seen;
    logic [31:0] a;
    logic [1:0]  r2;
    int r;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
    ifc.req_valid = 0; ifc.req_write = 0; ifc.req_addr = 0;
    ifc.req_wdata = 0; ifc.req_size = 2'b10; ifc.req_signed = 0;
    #1 mem_clr = 1'b0;

    // reset state
    repeat (2) @(negedge gclk);
    chk("rst_ready", 32'(ifc.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_strobes", {30'd0, ifc.mem_we, ifc.mem_re}, 32'd0);
    chk("rst_mem_addr", ifc.mem_addr, 32'd0);
    chk("rst_rsp", {ifc.rsp_rdata[30:0], ifc.rsp_err}, 32'd0);
    grst_n = 1'b1;
    @(negedge gclk);
    chk("ready_after_rst", 32'(ifc.req_ready), 32'd1);

    // directed word traffic and range/alignment boundaries
    do_req(1, 32'h10, 32'hdead_beef, 2'b10, 0);
    do_req(0, 32'h10, 32'h0, 2'b10, 0);
    do_req(0, 32'h12, 32'h0, 2'b10, 0);
    do_req(0, 32'h100, 32'h0, 2'b10, 0);
    do_req(1, 32'hfc, 32'h1234_5678, 2'b10, 0);
    do_req(0, 32'hfc, 32'h0, 2'b10, 0);
    do_req(1, 32'hffff_fffc, 32'h5555_aaaa, 2'b10, 0);
    do_req(0, 32'h0, 32'h0, 2'b10, 0);

`ifdef SUBWORD_EN
    do_req(1, 32'h10, 32'h8012_3456, 2'b10, 0);
    do_req(0, 32'h13, 32'h0, 2'b00, 1);
    do_req(0, 32'h10, 32'h0, 2'b01, 0);
    do_req(1, 32'h11, 32'h0000_00aa, 2'b00, 0);
    do_req(0, 32'h10, 32'h0, 2'b10, 0);
    do_req(0, 32'h11, 32'h0, 2'b01, 1);
    do_req(0, 32'h10, 32'h0, 2'b11, 0);
    do_req(1, 32'h22, 32'hbeef_c0de, 2'b01, 0);
`endif

    // back-to-back: valid held high across two loads
    ifc.req_write = 0; ifc.req_addr = 32'h0; ifc.req_size = 2'b10; ifc.req_valid = 1;
    t0 = -1; t1 = -1; low = 0; re = 0;
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      if (ifc.req_ready) begin if (t0 < 0) t0 = c; else t1 = c; end
      else low++;
      if (ifc.mem_re) re++;
      @(negedge gclk);
    end
    ifc.req_valid = 0;
    chk("b2b_gap", 32'(t1 - t0), 32'(L + 2));
    chk("b2b_ready_low", 32'(low), 32'(L + 1));
    chk("b2b_re_cycles", 32'(re), 32'(L));
    repeat (L + 1) @(negedge gclk);
    chk("b2b_drain_ready", 32'(ifc.req_ready), 32'd1);

    // reset in the second access cycle of a load
    ifc.req_write = 0; ifc.req_addr = 32'h4; ifc.req_valid = 1;
    @(negedge gclk); ifc.req_valid = 0;
    @(negedge gclk);
    chk("mid_re_before", 32'(ifc.mem_re), 32'd1);
    #2 grst_n = 1'b0;
    #1;
    chk("mid_re_async", 32'(ifc.mem_re), 32'd0);
    chk("mid_ready", 32'(ifc.req_ready), 32'd0);
    seen = 0;
    repeat (2) begin @(negedge gclk); if (ifc.rsp_valid) seen++; end
    grst_n = 1'b1;
    for (int c = 0; c < L + 2; c++) begin
      @(negedge gclk);
      if (ifc.rsp_valid) seen++;
      if (c == 0) chk("mid_ready_release", 32'(ifc.req_ready), 32'd1);
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (r >= 5) a[1:0] = 2'($urandom_range(0, 3));
      end else if (r == 7) a = 32'($urandom_range(DEPTH * 4, DEPTH * 16));
      else a = $urandom;
`ifdef SUBWORD_EN
      r2 = 2'($urandom_range(0, 3));
`else
      r2 = 2'($urandom_range(0, 3));
      if (r < 5) a[1:0] = 2'b00;
`endif
      do_req(1'($urandom_range(0, 1)), a, $urandom, r2, 1'($urandom_range(0, 1)));
    end

    // memory contents left by the DUT match the reference memory
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("mem[%0d]", i), tbwr[i] ? tbmem[i] : seed(i), ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
